// File: rtl/rally_controller.sv
`default_nettype none
// ============================================================================
// rally_controller : ball, speed, hit-window, scoring and game-over sequencer
//                    for the 16-LED tennis display (left = bit 15, right = bit 0)
// Revision 1.0
// ============================================================================
module rally_controller #(
  parameter int INIT_DIV    = 8,
  parameter int MIN_DIV     = 2,
  parameter int HIT_WIN     = 3,
  parameter int PAUSE_TICKS = 16,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        left_hit,
  input  logic        right_hit,
  output logic [15:0] ball,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [7:0]  rally_cnt,
  output logic        game_over
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_move_r = 3'd1;
  localparam logic [2:0] c_move_l = 3'd2;
  localparam logic [2:0] c_point  = 3'd3;
  localparam logic [2:0] c_over   = 3'd4;

  localparam logic [3:0] c_init_div   = 4'(INIT_DIV);
  localparam logic [3:0] c_min_div    = 4'(MIN_DIV);
  localparam logic [3:0] c_lo_win     = 4'(HIT_WIN - 1);
  localparam logic [3:0] c_hi_win     = 4'(16 - HIT_WIN);
  localparam logic [3:0] c_win        = 4'(WIN_SCORE);
  localparam logic [7:0] c_pause_last = 8'(PAUSE_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic        server_q, server_d;          // 0 = left serves, 1 = right serves
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  div_q, div_d;
  logic [3:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  pause_cnt_q, pause_cnt_d;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic [7:0]  rally_q, rally_d;
  logic [15:0] ball_q, ball_d;
  logic        game_over_q, game_over_d;

  logic        w_step;
  logic [3:0]  w_div_dec;
  logic [7:0]  w_rally_inc;
  logic [3:0]  w_score_l_inc;
  logic [3:0]  w_score_r_inc;

  assign w_step        = tick && (step_cnt_q == div_q - 4'd1);
  assign w_div_dec     = (div_q > c_min_div) ? div_q - 4'd1 : c_min_div;
  assign w_rally_inc   = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
  assign w_score_l_inc = (score_l_q == c_win) ? score_l_q : score_l_q + 4'd1;
  assign w_score_r_inc = (score_r_q == c_win) ? score_r_q : score_r_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= c_idle;
      server_q    <= 1'b0;
      pos_q       <= 4'd15;
      div_q       <= c_init_div;
      step_cnt_q  <= 4'd0;
      pause_cnt_q <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      rally_q     <= 8'd0;
      ball_q      <= 16'h8000;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      server_q    <= server_d;
      pos_q       <= pos_d;
      div_q       <= div_d;
      step_cnt_q  <= step_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      rally_q     <= rally_d;
      ball_q      <= ball_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    server_d    = server_q;
    pos_d       = pos_q;
    div_d       = div_q;
    step_cnt_d  = step_cnt_q;
    pause_cnt_d = pause_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    rally_d     = rally_q;
    unique case (state_q)
      c_idle: begin
        step_cnt_d  = 4'd0;
        pause_cnt_d = 8'd0;
        if (!server_q && left_hit) begin
          state_d = c_move_r;
          rally_d = 8'd0;
        end else if (server_q && right_hit) begin
          state_d = c_move_l;
          rally_d = 8'd0;
        end
      end
      // A return in the window takes priority over a step on the same cycle.
      c_move_r: begin
        if (right_hit && (pos_q <= c_lo_win)) begin
          state_d    = c_move_l;
          step_cnt_d = 4'd0;
          div_d      = w_div_dec;
          rally_d    = w_rally_inc;
        end else if (w_step) begin
          step_cnt_d = 4'd0;
          if (pos_q == 4'd0) begin
            state_d     = c_point;
            pause_cnt_d = 8'd0;
            score_l_d   = w_score_l_inc;
            server_d    = 1'b1;
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end else if (tick) begin
          step_cnt_d = step_cnt_q + 4'd1;
        end
      end
      c_move_l: begin
        if (left_hit && (pos_q >= c_hi_win)) begin
          state_d    = c_move_r;
          step_cnt_d = 4'd0;
          div_d      = w_div_dec;
          rally_d    = w_rally_inc;
        end else if (w_step) begin
          step_cnt_d = 4'd0;
          if (pos_q == 4'd15) begin
            state_d     = c_point;
            pause_cnt_d = 8'd0;
            score_r_d   = w_score_r_inc;
            server_d    = 1'b0;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else if (tick) begin
          step_cnt_d = step_cnt_q + 4'd1;
        end
      end
      c_point: begin
        step_cnt_d = 4'd0;
        if (tick) begin
          if (pause_cnt_q == c_pause_last) begin
            pause_cnt_d = 8'd0;
            if ((score_l_q == c_win) || (score_r_q == c_win)) begin
              state_d = c_over;
            end else begin
              state_d = c_idle;
              pos_d   = server_q ? 4'd0 : 4'd15;
              div_d   = c_init_div;
            end
          end else begin
            pause_cnt_d = pause_cnt_q + 8'd1;
          end
        end
      end
      c_over: begin
        step_cnt_d = 4'd0;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_comb begin
    ball_d      = 16'h0000;
    game_over_d = 1'b0;
    unique case (state_d)
      c_idle, c_move_r, c_move_l: ball_d = 16'd1 << pos_d;
      c_over: begin
        ball_d      = 16'hFFFF;
        game_over_d = 1'b1;
      end
      default: ball_d = 16'h0000;
    endcase
  end

  assign ball        = ball_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign rally_cnt   = rally_q;
  assign game_over   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_rally_controller.sv
`default_nettype none
// Bench for rally_controller: a game-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_rally_controller;

  localparam int INIT_DIV    = 8;
  localparam int MIN_DIV     = 2;
  localparam int HIT_WIN     = 3;
  localparam int PAUSE_TICKS = 16;
  localparam int WIN_SCORE   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        left_hit = 1'b0;
  logic        right_hit = 1'b0;
  logic [15:0] ball;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic [7:0]  rally_cnt;
  logic        game_over;

  int tests = 0;
  int fails = 0;

  rally_controller #(
    .INIT_DIV(INIT_DIV), .MIN_DIV(MIN_DIV), .HIT_WIN(HIT_WIN),
    .PAUSE_TICKS(PAUSE_TICKS), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .left_hit(left_hit), .right_hit(right_hit),
    .ball(ball), .score_left(score_left), .score_right(score_right),
    .rally_cnt(rally_cnt), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Game model: phase 0 waiting for serve, 1 ball in flight, 2 pause after a point, 3 over.
  // Direction -1 travels toward the right player (bit 0), +1 toward the left player.
  int m_phase = 0;
  int m_pos = 15;
  int m_dir = -1;
  int m_server = 0;
  int m_speed = INIT_DIV;
  int m_ticks = 0;
  int m_pause = 0;
  int m_sl = 0;
  int m_sr = 0;
  int m_rally = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_pos = 15; m_dir = -1; m_server = 0; m_speed = INIT_DIV;
      m_ticks = 0; m_pause = 0; m_sl = 0; m_sr = 0; m_rally = 0;
    end else begin
      case (m_phase)
        0: begin
          if ((m_server == 0 && left_hit) || (m_server == 1 && right_hit)) begin
            m_phase = 1;
            m_dir   = (m_server == 0) ? -1 : 1;
            m_ticks = 0;
            m_rally = 0;
          end
        end
        1: begin
          bit ret;
          int nxt;
          ret = (m_dir < 0) ? (right_hit && m_pos < HIT_WIN) : (left_hit && m_pos > 15 - HIT_WIN);
          if (ret) begin
            m_dir   = -m_dir;
            m_ticks = 0;
            m_speed = (m_speed - 1 < MIN_DIV) ? MIN_DIV : m_speed - 1;
            m_rally = (m_rally == 255) ? 255 : m_rally + 1;
          end else if (tick) begin
            m_ticks++;
            if (m_ticks == m_speed) begin
              m_ticks = 0;
              nxt = m_pos + m_dir;
              if (nxt < 0 || nxt > 15) begin
                if (m_dir < 0) begin m_sl++; m_server = 1; end
                else begin m_sr++; m_server = 0; end
                m_phase = 2;
                m_pause = 0;
              end else begin
                m_pos = nxt;
              end
            end
          end
        end
        2: begin
          if (tick) begin
            m_pause++;
            if (m_pause == PAUSE_TICKS) begin
              if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) m_phase = 3;
              else begin
                m_phase = 0;
                m_pos   = (m_server == 1) ? 0 : 15;
                m_speed = INIT_DIV;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] eb;
    eb = (m_phase == 2) ? 16'h0000 : (m_phase == 3) ? 16'hFFFF : 16'(32'd1 << m_pos);
    check("model.ball", {16'h0, ball}, {16'h0, eb});
    check("model.score_left", {28'h0, score_left}, 32'(m_sl));
    check("model.score_right", {28'h0, score_right}, 32'(m_sr));
    check("model.rally_cnt", {24'h0, rally_cnt}, 32'(m_rally));
    check("model.game_over", {31'h0, game_over}, {31'h0, m_phase == 3});
  end

  task automatic cyc(input logic t, input logic l, input logic r);
    tick = t; left_hit = l; right_hit = r;
    @(posedge clk);
    #1;
    tick = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL timeout %s: wait budget expired", nm);
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check({nm, ".ball"}, {16'h0, ball}, 32'h8000);
    check({nm, ".scores"}, {24'h0, score_left, score_right}, 32'h0);
    check({nm, ".rally"}, {24'h0, rally_cnt}, 32'h0);
    check({nm, ".game_over"}, {31'h0, game_over}, 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_window(input string nm);
    int g;
    g = 0;
    while (!(m_phase == 1 && ((m_dir < 0 && m_pos < HIT_WIN) || (m_dir > 0 && m_pos > 15 - HIT_WIN)))
           && g < 600) begin
      cyc(1'b1, 1'b0, 1'b0);
      g++;
    end
    if (g >= 600) timeout(nm);
  endtask

  initial begin
    int g;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ball", {16'h0, ball}, 32'h8000);
    @(negedge clk);
    #1 reset = 1'b1;

    // Idle with ticks only: nothing moves
    repeat (100) cyc(1'b1, 1'b0, 1'b0);
    check("idle.ball", {16'h0, ball}, 32'h8000);
    check("idle.scores", {24'h0, score_left, score_right}, 32'h0);

    // Left serve, unreturned ball
    cyc(1'b0, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    check("serve.first_step", {16'h0, ball}, 32'h4000);
    repeat (120) cyc(1'b1, 1'b0, 1'b0);
    check("miss.score_left", {28'h0, score_left}, 32'd1);
    check("miss.ball_blank", {16'h0, ball}, 32'h0);
    repeat (15) cyc(1'b1, 1'b0, 1'b0);
    check("pause.still_blank", {16'h0, ball}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    check("pause.right_serves", {16'h0, ball}, 32'h0001);

    // Right serve, left returns at pos 13, then a run of returns down to the speed clamp
    cyc(1'b0, 1'b0, 1'b1);
    repeat (104) cyc(1'b1, 1'b0, 1'b0);
    check("rally.pos13", {16'h0, ball}, 32'h2000);
    cyc(1'b0, 1'b1, 1'b0);
    check("rally.first_return", {24'h0, rally_cnt}, 32'd1);
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    check("rally.step_after_7", {16'h0, ball}, 32'h1000);
    for (int n = 0; n < 6; n++) begin
      wait_window("rally.window");
      if (m_dir < 0) cyc(1'b0, 1'b0, 1'b1);
      else cyc(1'b0, 1'b1, 1'b0);
    end
    check("rally.count7", {24'h0, rally_cnt}, 32'd7);

    // Right press outside the window is ignored; left then scores
    g = 0;
    while (!(m_dir < 0 && m_pos == 5) && g < 200) begin cyc(1'b1, 1'b0, 1'b0); g++; end
    if (g >= 200) timeout("outside.reach5");
    cyc(1'b0, 1'b0, 1'b1);
    check("outside.ignored", {16'h0, ball}, 32'h0020);
    g = 0;
    while (m_phase != 2 && g < 200) begin cyc(1'b1, 1'b0, 1'b0); g++; end
    if (g >= 200) timeout("outside.point");
    check("outside.left_scores", {28'h0, score_left}, 32'd2);

    // Right serves, left returns, right hits on the very cycle the miss step fires
    g = 0;
    while (m_phase != 0 && g < 200) begin cyc(1'b1, 1'b0, 1'b0); g++; end
    if (g >= 200) timeout("coinc.idle");
    cyc(1'b0, 1'b0, 1'b1);
    wait_window("coinc.left_window");
    cyc(1'b0, 1'b1, 1'b0);
    g = 0;
    while (!(m_dir < 0 && m_pos == 0 && m_ticks == m_speed - 1) && g < 400) begin
      cyc(1'b1, 1'b0, 1'b0); g++;
    end
    if (g >= 400) timeout("coinc.reach0");
    cyc(1'b1, 1'b0, 1'b1);
    check("coinc.ball_held", {16'h0, ball}, 32'h0001);
    check("coinc.no_score", {24'h0, score_left, score_right}, 32'h20);
    check("coinc.rally", {24'h0, rally_cnt}, 32'd2);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    async_reset_check("midrally_reset");

    // Randomized play
    for (int i = 0; i < 15000; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2999) == 0 || (m_phase == 3 && $urandom_range(0, 49) == 0)) begin
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end

    // Left wins every point down to 7-0
    async_reset_check("pregame_reset");
    g = 0;
    while (m_phase != 3 && g < 20000) begin
      if (m_phase == 0) cyc(1'b0, m_server == 0, m_server == 1);
      else if (m_phase == 1 && m_dir > 0 && m_pos > 15 - HIT_WIN) cyc(1'b0, 1'b1, 1'b0);
      else cyc(1'b1, 1'b0, 1'b0);
      g++;
    end
    if (g >= 20000) timeout("game.over");
    check("over.game_over", {31'h0, game_over}, 32'd1);
    check("over.ball", {16'h0, ball}, 32'hFFFF);
    check("over.scores", {24'h0, score_left, score_right}, 32'h70);
    repeat (6) cyc(1'b1, 1'b1, 1'b1);
    check("over.hits_ignored", {15'h0, game_over, ball}, 32'h1FFFF);
    async_reset_check("over_reset");
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
